hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. It sits beside the forwarding unit and decides, every cycle, which pipeline registers hold, which take a bubble, and when the PC redirects. It handles four cases: load-use hazards, taken branches, a fixed-latency multiply/divide occupying EX, and data-memory wait states. It also keeps stall and flush performance counters.

## Interface
Parameters:
- MULDIV_LAT, 4: total cycles a mul/div instruction occupies EX; legal range 2..16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_is_load  in  1  instruction in EX is a load.
- id_ex_rd  in  5  destination register of the instruction in EX.
- if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads rs1 / rs2.
- branch_taken  in  1  EX resolved a taken branch or jump.
- muldiv_req  in  1  instruction in EX is a mul/div op.
- dmem_busy  in  1  memory access in MEM is not complete this cycle.
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the named register.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble into the named register.
- pc_redirect  out  1  select the branch target for the PC.
- muldiv_done  out  1  mul/div result valid this cycle; EX advances.
- stall_cycles  out  32  count of cycles with pc_stall=1.
- flush_count  out  32  count of taken-branch flushes.

## Operation
- FSM with two states: RUN and MD_WAIT. Registered state: state, cnt[3:0], and both counters. All control outputs are combinational from state, cnt and the inputs.
- Reset:
  - state=RUN, cnt=0, both counters=0.
  - While rst=1, all four flush outputs are 1.
  - While rst=1, all stall outputs, pc_redirect and muldiv_done are 0.
- Priority per cycle, highest first:
  1. **MEM freeze** (dmem_busy=1):
     - pc/if_id/id_ex/ex_mem stall=1 and mem_wb_flush=1.
     - State and cnt hold.
     - branch_taken, muldiv_req and load-use are ignored this cycle.
  2. **MD_WAIT**:
     - If cnt≠0: pc/if_id/id_ex stall=1, ex_mem_flush=1, cnt decrements.
     - If cnt=0: muldiv_done=1, no stalls, next state RUN.
  3. **RUN with muldiv_req=1**:
     - Same stalls and flush as MD_WAIT with cnt≠0.
     - cnt loads MULDIV_LAT-2; next state MD_WAIT.
     - branch_taken is ignored; simultaneous assertion with muldiv_req is illegal.
  4. **Taken branch** (branch_taken=1):
     - pc_redirect=1, if_id_flush=1, id_ex_flush=1.
     - flush_count increments.
     - A simultaneous load-use hazard is suppressed, since it belongs to the wrong path.
  5. **Load-use hazard**, detected when all of the following hold:
     - ex_is_load=1 and id_ex_rd≠0;
     - id_ex_rd==if_id_rs1 with id_uses_rs1=1, or id_ex_rd==if_id_rs2 with id_uses_rs2=1.
     - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1, for exactly one bubble.
  6. Otherwise all control outputs are 0.
- When stall and flush are both asserted on the same register, stall wins; the register holds.
- Counters are 32-bit and wrap from 2^32-1 to 0. They are cleared only by rst.

## Timing
- All control outputs have zero latency: they reflect the current cycle's inputs.
- Mul/div occupies EX for exactly MULDIV_LAT cycles, counted from the first cycle muldiv_req is seen in RUN.
  - The first MULDIV_LAT-1 of those cycles are stalled.
  - muldiv_done is asserted in the last cycle.
- Back-to-back mul/div: the next request is seen in RUN on the cycle after muldiv_done, with no idle gap.
- A dmem_busy assertion in the middle of MD_WAIT extends the total latency by the number of busy cycles; cnt does not decrement during those cycles.
- A load-use hazard costs exactly 1 cycle. The hazard clears on its own once the load moves to MEM, and forwarding then supplies the operand.
- stall_cycles updates on the edge ending each cycle where pc_stall=1, including MEM-freeze cycles.
- rst asserted in the middle of MD_WAIT: the next cycle is RUN with cnt=0, and no muldiv_done pulse is issued.

## Test plan
- **Load-use:** ex_is_load=1, id_ex_rd=5, if_id_rs2=5, id_uses_rs2=1.
  - Expect pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle; stall_cycles 0→1.
  - Repeat with id_ex_rd=0: expect no stall.
- **Branch over load-use:** branch_taken=1 together with the load-use condition.
  - Expect pc_redirect=if_id_flush=id_ex_flush=1, pc_stall=0, flush_count=1.
- **Mul/div:** MULDIV_LAT=4, muldiv_req=1 at cycle 10.
  - Expect stalls and ex_mem_flush at cycles 10–12, muldiv_done=1 at cycle 13, RUN at cycle 14.
  - A second request at cycle 14 must repeat the same pattern.
- **Freeze inside mul/div:** as above, with dmem_busy=1 at cycles 11–12.
  - Expect mem_wb_flush at 11–12, muldiv_done at cycle 15, stall_cycles=5.
- **Reset mid-MD_WAIT:** rst=1 at cycle 11 for one cycle.
  - Expect all flushes=1 at cycle 11, state RUN and counters 0 at cycle 12, no muldiv_done.
- **Counter wrap:** force stall_cycles to 0xFFFFFFFF, then one stalled cycle.
  - Expect stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage RV32 core. Every cycle it decides
// which pipeline registers hold, which take a bubble, and whether the PC
// redirects. Four situations are handled, in priority order: data-memory wait
// states (whole-pipe freeze), a fixed-latency mul/div occupying EX, taken
// branches, and load-use hazards. Stall and flush performance counters are kept.
//
// Parameters
//   MULDIV_LAT   total cycles a mul/div occupies EX (legal 2..16)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ex_is_load, id_ex_rd          load in EX and its destination register
//   if_id_rs1/rs2, id_uses_rs1/2  source registers of ID and whether they are read
//   branch_taken                  EX resolved a taken branch/jump
//   muldiv_req                    EX holds a mul/div op
//   dmem_busy                     MEM access not complete this cycle
//   *_stall                       hold the named pipeline register
//   *_flush                       load a bubble into the named register
//   pc_redirect                   select branch target for the PC
//   muldiv_done                   mul/div result valid, EX advances
//   stall_cycles, flush_count     32-bit wrapping performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_is_load,
    input  logic [4:0]  id_ex_rd,
    input  logic [4:0]  if_id_rs1,
    input  logic [4:0]  if_id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        branch_taken,
    input  logic        muldiv_req,
    input  logic        dmem_busy,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        pc_redirect,
    output logic        muldiv_done,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    // The request cycle and the done cycle are not counted down, hence -2.
    localparam logic [3:0] LP_CNT_LOAD = 4'(MULDIV_LAT - 2);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic        w_load_use;
    logic        w_flush_inc;

    // A load writing x0 never creates a hazard; unused source fields are ignored.
    assign w_load_use = ex_is_load && (id_ex_rd != 5'd0) &&
                        (((id_ex_rd == if_id_rs1) && id_uses_rs1) ||
                         ((id_ex_rd == if_id_rs2) && id_uses_rs2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_cnt          <= 4'd0;
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (pc_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush_inc) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_flush_inc  = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        pc_redirect  = 1'b0;
        muldiv_done  = 1'b0;

        if (rst) begin
            // Bubble everything; the registered state is cleared by the reset edge.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            w_state_next = ST_RUN;
            w_cnt_next   = 4'd0;
        end else if (dmem_busy) begin
            // Whole-pipe freeze: state and cnt hold, so a mul/div is stretched.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (r_state == ST_MD_WAIT) begin
            if (r_cnt != 4'd0) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
                w_cnt_next   = r_cnt - 4'd1;
            end else begin
                muldiv_done  = 1'b1;
                w_state_next = ST_RUN;
            end
        end else if (muldiv_req) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            w_cnt_next   = LP_CNT_LOAD;
            w_state_next = ST_MD_WAIT;
        end else if (branch_taken) begin
            // A coincident load-use belongs to the wrong path and is dropped.
            pc_redirect = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_flush_inc = 1'b1;
        end else if (w_load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
